// File: rtl/display_source_scheduler_pkg.sv
// Shared types and widths for the display source scheduler.
// Imported by the interface, the round-robin picker and the top.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FADE_IN,
        SHOW,
        FADE_OUT
    } sched_state_t;

    localparam int LUM_W  = 4;
    localparam int DIGITS = 4;
    localparam int HEX_W  = 16;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_source_scheduler_if.sv
// Source-side and driver-side bundle of the display source scheduler.
// master = producers/driver side, slave = the scheduler.
interface display_source_scheduler_if #(
    parameter int NUM_SRC = 3
);
    import display_pkg::*;

    localparam int IDX_W = clog2_min1(NUM_SRC);

    logic [NUM_SRC-1:0]        src_valid;
    logic [HEX_W*NUM_SRC-1:0]  src_hexx;
    logic [DIGITS*NUM_SRC-1:0] src_points;
    logic [LUM_W-1:0]          max_lum;

    logic                      disp_en;
    logic [LUM_W-1:0]          disp_lum;
    logic [HEX_W-1:0]          disp_hexx;
    logic [DIGITS-1:0]         disp_points;
    logic [IDX_W-1:0]          active_src;
    logic                      switch_pulse;

    modport master (
        output src_valid, src_hexx, src_points, max_lum,
        input  disp_en, disp_lum, disp_hexx, disp_points,
        input  active_src, switch_pulse
    );

    modport slave (
        input  src_valid, src_hexx, src_points, max_lum,
        output disp_en, disp_lum, disp_hexx, disp_points,
        output active_src, switch_pulse
    );

endinterface

// File: rtl/display_source_scheduler_rr_next_valid.sv
// Next source to show: index 0 wins, else the next valid index after cur
// in circular order, else cur itself if still valid.
module rr_next_valid
    import display_pkg::*;
#(
    parameter  int NUM_SRC = 3,
    localparam int IDX_W   = clog2_min1(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] valid,
    input  logic [IDX_W-1:0]   cur,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    function automatic logic [IDX_W-1:0] wrap(input int v);
        return IDX_W'(v % NUM_SRC);
    endfunction

    always_comb begin
        found = 1'b0;
        idx   = '0;
        if (valid[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k < NUM_SRC; k++) begin
                if (!found && valid[wrap(int'(cur) + k)]) begin
                    found = 1'b1;
                    idx   = wrap(int'(cur) + k);
                end
            end
            if (!found && valid[cur]) begin
                found = 1'b1;
                idx   = cur;
            end
        end
    end

endmodule

// File: rtl/display_source_scheduler.sv
// Rotates display content among sources with a fixed dwell and a
// luminance fade on every switch; source 0 preempts the rotation.
module display_source_scheduler
    import display_pkg::*;
#(
    parameter int NUM_SRC      = 3,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int STEP_CYCLES  = 1_000_000
) (
    input logic                       clk,
    input logic                       rst,
    display_source_scheduler_if.slave bus
);

    localparam int IDX_W   = clog2_min1(NUM_SRC);
    localparam int DWELL_W = clog2_min1(DWELL_CYCLES);
    localparam int STEP_W  = clog2_min1(STEP_CYCLES);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]   TOP_IDX    = IDX_W'(NUM_SRC - 1);

    sched_state_t       state_q, state_d;
    logic               disp_en_q, disp_en_d;
    logic [LUM_W-1:0]   disp_lum_q, disp_lum_d;
    logic [HEX_W-1:0]   disp_hexx_q, disp_hexx_d;
    logic [DIGITS-1:0]  disp_points_q, disp_points_d;
    logic [IDX_W-1:0]   active_src_q, active_src_d;
    logic               switch_pulse_q, switch_pulse_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;

    logic               nxt_found;
    logic [IDX_W-1:0]   nxt_idx;
    logic [IDX_W-1:0]   rr_cur;
    logic               cur_valid;
    logic               preempt;
    logic               tick;

    // From IDLE, searching "after the last index" yields the lowest valid one.
    assign rr_cur = (state_q == IDLE) ? TOP_IDX : active_src_q;

    rr_next_valid #(
        .NUM_SRC(NUM_SRC)
    ) u_rr (
        .valid(bus.src_valid),
        .cur  (rr_cur),
        .found(nxt_found),
        .idx  (nxt_idx)
    );

    assign cur_valid = bus.src_valid[active_src_q];
    assign preempt   = !cur_valid ||
                       (bus.src_valid[0] && (active_src_q != '0));
    assign tick      = (step_cnt_q == STEP_LAST);

    always_comb begin
        state_d        = state_q;
        disp_lum_d     = disp_lum_q;
        active_src_d   = active_src_q;
        switch_pulse_d = 1'b0;
        dwell_cnt_d    = dwell_cnt_q;
        step_cnt_d     = tick ? '0 : step_cnt_q + STEP_W'(1);
        disp_hexx_d    = disp_hexx_q;
        disp_points_d  = disp_points_q;

        if (cur_valid) begin
            disp_hexx_d   = bus.src_hexx[int'(active_src_q)*HEX_W +: HEX_W];
            disp_points_d = bus.src_points[int'(active_src_q)*DIGITS +: DIGITS];
        end

        unique case (state_q)
            IDLE: begin
                disp_lum_d = '0;
                if (|bus.src_valid) begin
                    active_src_d   = nxt_idx;
                    state_d        = FADE_IN;
                    switch_pulse_d = 1'b1;
                end
            end
            FADE_IN: begin
                if (preempt) begin
                    state_d = FADE_OUT;
                end else if (tick) begin
                    if (disp_lum_q >= bus.max_lum) begin
                        state_d    = SHOW;
                        disp_lum_d = bus.max_lum;
                    end else begin
                        disp_lum_d = disp_lum_q + LUM_W'(1);
                    end
                end
            end
            SHOW: begin
                disp_lum_d = bus.max_lum;
                if (preempt) begin
                    state_d = FADE_OUT;
                end else if (dwell_cnt_q == DWELL_LAST) begin
                    if (!nxt_found || (nxt_idx != active_src_q)) begin
                        state_d = FADE_OUT;
                    end else begin
                        dwell_cnt_d = '0;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
            FADE_OUT: begin
                if (tick) begin
                    if (disp_lum_q == '0) begin
                        if (nxt_found) begin
                            active_src_d   = nxt_idx;
                            state_d        = FADE_IN;
                            switch_pulse_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        disp_lum_d = disp_lum_q - LUM_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            step_cnt_d  = '0;
            dwell_cnt_d = '0;
        end
        disp_en_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            disp_en_q      <= 1'b0;
            disp_lum_q     <= '0;
            disp_hexx_q    <= '0;
            disp_points_q  <= '0;
            active_src_q   <= '0;
            switch_pulse_q <= 1'b0;
            dwell_cnt_q    <= '0;
            step_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            disp_en_q      <= disp_en_d;
            disp_lum_q     <= disp_lum_d;
            disp_hexx_q    <= disp_hexx_d;
            disp_points_q  <= disp_points_d;
            active_src_q   <= active_src_d;
            switch_pulse_q <= switch_pulse_d;
            dwell_cnt_q    <= dwell_cnt_d;
            step_cnt_q     <= step_cnt_d;
        end
    end

    assign bus.disp_en      = disp_en_q;
    assign bus.disp_lum     = disp_lum_q;
    assign bus.disp_hexx    = disp_hexx_q;
    assign bus.disp_points  = disp_points_q;
    assign bus.active_src   = active_src_q;
    assign bus.switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Bench for display_source_scheduler: directed scenarios plus random
// traffic, every cycle compared against a phase/age reference model.
module tb_display_source_scheduler;

    localparam int N     = 3;
    localparam int DWELL = 20;
    localparam int STEP  = 2;

    localparam int P_OFF  = 0;
    localparam int P_RISE = 1;
    localparam int P_HOLD = 2;
    localparam int P_FALL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    display_source_scheduler_if #(.NUM_SRC(N)) bus ();

    display_source_scheduler #(
        .NUM_SRC     (N),
        .DWELL_CYCLES(DWELL),
        .STEP_CYCLES (STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          m_ph    = P_OFF;
    int          m_age   = 0;
    int          m_start = 0;
    int          m_act   = 0;
    int          m_lum   = 0;
    logic [15:0] m_hexx  = '0;
    logic [3:0]  m_pts   = '0;
    logic        m_pulse = 1'b0;

    function automatic int nsel(input logic [2:0] v, input int cur);
        if (v[0]) return 0;
        for (int k = 1; k < N; k++)
            if (v[(cur + k) % N]) return (cur + k) % N;
        if (v[cur]) return cur;
        return -1;
    endfunction

    function automatic int lowest(input logic [2:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each phase has an age; luminance follows from the age.
    task automatic model_step();
        logic [2:0] v;
        int         mx;
        int         nx;
        bit         early;
        v  = bus.src_valid;
        mx = int'(bus.max_lum);
        if (rst) begin
            m_ph = P_OFF; m_age = 0; m_start = 0; m_act = 0;
            m_hexx = '0; m_pts = '0; m_pulse = 1'b0;
        end else begin
            if (v[m_act]) begin
                m_hexx = bus.src_hexx[16*m_act +: 16];
                m_pts  = bus.src_points[4*m_act +: 4];
            end
            m_pulse = 1'b0;
            early = (m_ph == P_RISE || m_ph == P_HOLD) &&
                    (!v[m_act] || (v[0] && m_act != 0));
            if (early) begin
                m_start = (m_ph == P_HOLD) ? mx : m_lum;
                m_ph = P_FALL; m_age = 0;
            end else begin
                case (m_ph)
                    P_OFF: if (v != 0) begin
                        m_act = lowest(v); m_ph = P_RISE;
                        m_age = 0; m_pulse = 1'b1;
                    end
                    P_RISE: if (m_age == (mx + 1) * STEP - 1) begin
                        m_ph = P_HOLD; m_age = 0;
                    end else m_age++;
                    P_HOLD: if (m_age % DWELL == DWELL - 1 &&
                                nsel(v, m_act) != m_act) begin
                        m_start = mx; m_ph = P_FALL; m_age = 0;
                    end else m_age++;
                    default: if (m_age == (m_start + 1) * STEP - 1) begin
                        nx = nsel(v, m_act);
                        if (nx >= 0) begin
                            m_act = nx; m_ph = P_RISE; m_pulse = 1'b1;
                        end else m_ph = P_OFF;
                        m_age = 0;
                    end else m_age++;
                endcase
            end
        end
        case (m_ph)
            P_OFF:   m_lum = 0;
            P_RISE:  m_lum = m_age / STEP;
            P_HOLD:  m_lum = mx;
            default: m_lum = m_start - m_age / STEP;
        endcase
    endtask

    task automatic check_outputs();
        chk("en",     bus.disp_en,      m_ph != P_OFF);
        chk("lum",    bus.disp_lum,     m_lum);
        chk("hexx",   bus.disp_hexx,    m_hexx);
        chk("points", bus.disp_points,  m_pts);
        chk("active", bus.active_src,   m_act);
        chk("pulse",  bus.switch_pulse, m_pulse);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    initial begin
        int pulses, mpulses, dips, guard;
        bit seen2, saw0;
        int revisit;

        bus.src_valid  = '0;
        bus.src_hexx   = '0;
        bus.src_points = '0;
        bus.max_lum    = 4'd3;
        rst = 1'b1;
        repeat (2) cycle();

        // single source fade-in and capture
        rst = 1'b0;
        bus.src_valid  = 3'b010;
        bus.src_hexx   = 48'h5555_1234_AAAA;
        bus.src_points = 12'h0A5;
        repeat (10) cycle();
        chk("s1_lum",  bus.disp_lum,    3);
        chk("s1_hexx", bus.disp_hexx,   16'h1234);
        chk("s1_act",  bus.active_src,  1);
        chk("s1_pts",  bus.disp_points, 4'hA);

        // rotation between 1 and 2
        bus.src_valid = 3'b110;
        bus.src_hexx  = 48'h2222_1111_0000;
        seen2 = 0; pulses = 0; mpulses = 0;
        repeat (120) begin
            cycle();
            if (bus.active_src == 2) seen2 = 1;
            if (bus.switch_pulse) pulses++;
            if (m_pulse) mpulses++;
        end
        chk("s2_saw_src2", seen2, 1);
        chk("s2_pulses", pulses, mpulses);

        // single source never leaves SHOW
        bus.src_valid = 3'b010;
        repeat (40) cycle();
        pulses = 0; dips = 0;
        repeat (60) begin
            cycle();
            if (bus.switch_pulse) pulses++;
            if (bus.disp_lum != 4'd3) dips++;
        end
        chk("s3_pulses", pulses, 0);
        chk("s3_dips", dips, 0);
        chk("s3_act", bus.active_src, 1);

        // source 0 preempts source 2
        bus.src_valid = 3'b100;
        repeat (40) cycle();
        chk("s4_act", bus.active_src, 2);
        chk("s4_lum", bus.disp_lum, 3);
        bus.src_valid = 3'b101;
        cycle();
        chk("s4_lum_hold", bus.disp_lum, 3);
        saw0 = 0; revisit = 0;
        repeat (60) begin
            cycle();
            if (bus.active_src == 0) saw0 = 1;
            else if (saw0 && bus.active_src == 2) revisit++;
        end
        chk("s4_saw0", saw0, 1);
        chk("s4_revisit", revisit, 0);

        // abort of fade-in at lum 1, then idle with held content
        bus.src_valid = 3'b000;
        repeat (20) cycle();
        chk("s5_idle_en", bus.disp_en, 0);
        bus.src_hexx  = 48'h0000_BEEF_0000;
        bus.src_valid = 3'b010;
        guard = 0;
        while (bus.disp_lum != 4'd1 && guard < 30) begin
            cycle();
            guard++;
        end
        chk("s5_reached_lum1", guard < 30, 1);
        bus.src_valid = 3'b000;
        bus.src_hexx  = 48'hFFFF_0000_FFFF;
        repeat (10) cycle();
        chk("s5_en", bus.disp_en, 0);
        chk("s5_hexx", bus.disp_hexx, 16'hBEEF);

        // reset in SHOW
        bus.src_valid = 3'b010;
        bus.src_hexx  = 48'h0000_7777_0000;
        repeat (30) cycle();
        chk("s6_lum", bus.disp_lum, 3);
        rst = 1'b1;
        cycle();
        chk("s6_rst_en",    bus.disp_en,      0);
        chk("s6_rst_lum",   bus.disp_lum,     0);
        chk("s6_rst_hexx",  bus.disp_hexx,    0);
        chk("s6_rst_pts",   bus.disp_points,  0);
        chk("s6_rst_act",   bus.active_src,   0);
        chk("s6_rst_pulse", bus.switch_pulse, 0);
        rst = 1'b0;
        cycle();
        chk("s6_restart_pulse", bus.switch_pulse, 1);
        chk("s6_restart_lum",   bus.disp_lum,     0);
        chk("s6_restart_act",   bus.active_src,   1);

        // random traffic, max_lum changes only across resets
        for (int i = 0; i < 1500; i++) begin
            if (i == 0) begin
                rst = 1'b1; bus.max_lum = 4'd0;
            end else if (i == 500) begin
                rst = 1'b1; bus.max_lum = 4'd15;
            end else if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1; bus.max_lum = 4'($urandom_range(0, 15));
            end else begin
                rst = 1'b0;
            end
            if ($urandom_range(0, 29) == 0)
                bus.src_valid = 3'($urandom_range(0, 7));
            bus.src_hexx   = 48'({$urandom(), $urandom()});
            bus.src_points = 12'($urandom());
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Sequences the 4-digit 7-segment display driver (hexx/points/luminance/en inputs) among NUM_SRC content sources.
- Round-robins between valid sources with a fixed dwell time per source.
- Fades luminance down and up on every source change. Source 0 is the priority (alert) source and preempts the rotation.
- Sits between the application producers and the display driver instance; the driver itself is unchanged.

Parameters:
- NUM_SRC, 3, number of content sources (2..8).
- DWELL_CYCLES, 50_000_000, cycles a source is shown in SHOW before rotation is considered (≥2).
- STEP_CYCLES, 1_000_000, cycles per luminance step during fades (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- src_valid  in  NUM_SRC  per-source "has content to show"
- src_hexx  in  16*NUM_SRC  source i digits at [16i+15:16i]
- src_points  in  4*NUM_SRC  source i decimal points at [4i+3:4i]
- max_lum  in  4  target luminance in SHOW
- disp_en  out  1  to driver en
- disp_lum  out  4  to driver luminance
- disp_hexx  out  16  to driver hexx
- disp_points  out  4  to driver points
- active_src  out  max(1,$clog2(NUM_SRC))  index of the currently selected source
- switch_pulse  out  1  one-cycle pulse on entry to FADE_IN

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high. All outputs are registered.
- Reset values: state=IDLE, disp_en=0, disp_lum=0, disp_hexx=0, disp_points=0, active_src=0, switch_pulse=0, all counters=0. Reset asserted mid-operation forces these values on the next edge, with no fade.
- States: IDLE, FADE_IN, SHOW, FADE_OUT. disp_en=1 in all states except IDLE.
- next_sel (combinational):
  - 0 if src_valid[0];
  - else the first valid index after active_src in circular order, excluding active_src;
  - else active_src if it is still valid;
  - else none.
- IDLE: when any src_valid bit is set, latch active_src=next_sel (search starts from index 0), go to FADE_IN with disp_lum=0.
- Content capture:
  - While src_valid[active_src]=1, disp_hexx and disp_points register that source's data every cycle (one-cycle latency).
  - While it is 0, they hold their last value.
- Step tick: asserted when step_cnt==STEP_CYCLES-1. step_cnt is cleared on every state entry and wraps at each tick.
- FADE_IN:
  - At each tick: if disp_lum>=max_lum, go to SHOW and set disp_lum=max_lum; else disp_lum+1.
  - Duration is (max_lum+1)*STEP_CYCLES.
- SHOW:
  - disp_lum tracks max_lum every cycle.
  - dwell_cnt counts up from 0.
  - When dwell_cnt==DWELL_CYCLES-1: if next_sel!=active_src, go to FADE_OUT; else clear dwell_cnt and stay (single source, no fade).
- Early FADE_OUT: FADE_IN or SHOW goes immediately to FADE_OUT if src_valid[active_src] drops, or if src_valid[0] rises while active_src!=0.
- FADE_OUT:
  - At each tick: if disp_lum==0, evaluate next_sel. If it exists, set active_src, go to FADE_IN and pulse switch_pulse. Otherwise go to IDLE.
  - Else disp_lum-1 at each tick.
  - FADE_OUT always completes; no abort.
- Simultaneous events: preemption by source 0 and dwell expiry in the same cycle both produce FADE_OUT. Reset has precedence over everything.
- Arithmetic: luminance is 4-bit unsigned with no wrap; it is clamped by the rules above. dwell_cnt and step_cnt are sized $clog2 of their parameter.
- max_lum=0: FADE_IN takes one STEP_CYCLES at lum 0, then SHOW. FADE_OUT from lum 0 takes one tick.

Decomposition:
- Shared package display_pkg holds:
  - the state enum sched_state_t {IDLE, FADE_IN, SHOW, FADE_OUT};
  - LUM_W=4, DIGITS=4, HEX_W=16.
- One sub-module, rr_next_valid: combinational next_sel from (valid vector, current index, priority index 0), parameterised by NUM_SRC, returning {found, index}.

Test Plan (all tests use NUM_SRC=3, DWELL_CYCLES=20, STEP_CYCLES=2, max_lum=3):
- Reset, then src_valid=3'b010, src1 hexx=16'h1234 → IDLE one cycle, then FADE_IN; switch_pulse for 1 cycle; active_src=1; disp_lum 0,0,1,1,2,2,3,3; SHOW after 8 cycles; disp_hexx=16'h1234.
- src_valid=3'b110, steady in SHOW on 1 → after 20 SHOW cycles, FADE_OUT: disp_lum 3→0 over 8 cycles; then active_src=2, FADE_IN. Repeats alternating 1,2.
- Only src1 valid, SHOW for 60 cycles → never leaves SHOW; disp_lum stays 3; no switch_pulse.
- In SHOW on src2 at lum 3, src_valid[0] rises → FADE_OUT on the next cycle; then active_src=0; src2 is not revisited while src0 stays valid.
- In FADE_IN at lum 1, src_valid drops to 0 → FADE_OUT: lum 1,1,0,0; then IDLE with disp_en=0; disp_hexx holds the last value.
- rst pulsed for 1 cycle in SHOW at lum 3 → next cycle all outputs equal reset values with state IDLE; with src_valid still set, FADE_IN restarts from lum 0.
